pic_move_ctrl: RTL and testbench
================================

# pic_move_ctrl

Position and read-sequencing controller for the picture ROM in the VGA path. Each frame it moves a WIDTH×HEIGHT picture window across the H_DISP×V_DISP display, bouncing off the edges. It then drives the ROM read enable and address for the active pixel stream. It sits between the VGA timing driver (pixel_xpos/pixel_ypos) and the picture ROM, and replaces fixed-origin display with a moving one.

## Interface
Parameters:
- H_DISP, 640: active pixels per line
- V_DISP, 480: active lines per frame
- WIDTH, 350: picture width in pixels
- HEIGHT, 350: picture height in lines
- ADDR_W, 17: ROM address width (must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT)

Ports:
- vga_clk  in  1  pixel clock; the only clock
- sys_rst  in  1  synchronous, active-high reset
- pixel_xpos  in  10  current pixel column
- pixel_ypos  in  10  current pixel row
- move_en  in  1  1 = move per frame; 0 = freeze position
- step  in  4  pixels moved per frame on each axis, 0–15
- rom_rd_en  out  1  ROM read enable (combinational, in-window)
- rom_addr  out  ADDR_W  ROM read address (registered)
- rom_valid  out  1  ROM q valid for the current pixel
- pos_x  out  10  committed window origin X
- pos_y  out  10  committed window origin Y
- frame_tick  out  1  one-cycle pulse on position commit

## Operation
- rom_rd_en = pos_x ≤ xpos < pos_x+WIDTH and pos_y ≤ ypos < pos_y+HEIGHT. Uses committed pos only. Compare in 11 bits.
- rom_addr increments on every cycle where rom_rd_en=1. At WIDTH*HEIGHT−1 it wraps to 0. It is forced to 0 in COMMIT, even if move_en=0.
- rom_valid <= rom_rd_en, giving one cycle of ROM latency.
- Frame end: rising edge of (xpos==H_DISP−1 && ypos==V_DISP−1), via a registered previous value.
- FSM, three states:
  - WAIT: on frame end, go to CALC.
  - CALC: latch step and move_en, then compute next_x/next_y per axis. Always goes to COMMIT.
  - COMMIT: pos <= next, rom_addr <= 0, frame_tick=1. Always goes to WAIT.
- Axis rule for X; Y is the same with V_DISP/HEIGHT. Let MAX_X = H_DISP−WIDTH (290) and MAX_Y = V_DISP−HEIGHT (130).
  - dir=+: if pos+step ≥ MAX, next=MAX and dir flips to −. Otherwise next=pos+step.
  - dir=−: if pos < step or pos−step == 0, next=0 and dir flips to +. Otherwise next=pos−step.
  - When the latched move_en=0 or step=0, next=pos and dir is unchanged.
- Clamp, then flip on the same update. The edge value is shown for exactly one frame.
- Frame end arriving while in CALC or COMMIT is ignored. This cannot happen with legal timing.

## Timing
- Reset values:
  - pos_x = (H_DISP−WIDTH)/2 = 145, pos_y = (V_DISP−HEIGHT)/2 = 65
  - dir_x = dir_y = +
  - rom_addr = 0, rom_valid = 0, frame_tick = 0
  - state = WAIT, edge-detect register = 0
- Reset mid-frame takes effect on the next edge. The display restarts at the origin on the following frame with address 0.
- Frame end is seen at cycle N (the cycle after the last active pixel). CALC runs at N+1 and COMMIT at N+2. New pos and frame_tick appear at N+3, all within blanking.
- rom_rd_en has zero latency from the coordinates. rom_valid lags rom_rd_en by 1 cycle.
- pos never changes during active video.

## Structure
- Shared package vga_pkg holds:
  - H_DISP and V_DISP defaults
  - RGB888 colour constants
  - the FSM state enum (WAIT, CALC, COMMIT)
- Sub-module bounce_axis, instantiated twice. Inputs: pos, dir, step, max. Outputs: next_pos, next_dir. Purely combinational with 11-bit arithmetic.
- The FSM, address counter and window compare stay in pic_move_ctrl.

## Test plan
- Reset:
  - assert sys_rst for 3 cycles → pos=(145,65), rom_addr=0, rom_valid=0, frame_tick=0.
  - assert sys_rst mid-line → same values on the next edge.
- Straight move: move_en=1, step=4, one full frame → frame_tick pulses once, 3 cycles after frame end. pos=(149,69).
- Edge clamp and reverse: pos_x=288 dir + with step=4 → pos_x=290. Next frame → 286.
- Left edge: pos_x=3 dir − with step=4 → 0, then 4.
- Freeze: move_en=0 over 2 frames → pos unchanged and dir unchanged. rom_addr still returns to 0 each COMMIT.
- Address sequencing at pos=(145,65):
  - first rd_en is at (145,65) with rom_addr=0.
  - rom_addr=349 at (494,65) and 350 at (145,66).
  - last rd_en at (494,414) with rom_addr=122499, then the address wraps to 0.
  - rom_valid tracks rd_en delayed by 1 cycle throughout.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA-path definitions: display defaults, colours,
// and the picture-mover FSM states.
package vga_pkg;

  localparam int H_DISP_DEF = 640;
  localparam int V_DISP_DEF = 480;

  localparam logic [23:0] RGB_BLACK = 24'h000000;
  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_RED   = 24'hFF0000;
  localparam logic [23:0] RGB_GREEN = 24'h00FF00;
  localparam logic [23:0] RGB_BLUE  = 24'h0000FF;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_CALC,
    ST_COMMIT
  } move_state_t;

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing window: clamp at an edge and
// reverse direction on the same update.
module bounce_axis
  import vga_pkg::*;
(
  input  logic [9:0] pos,
  input  logic       dir,
  input  logic [3:0] step,
  input  logic [9:0] max,
  output logic [9:0] next_pos,
  output logic       next_dir
);

  logic [10:0] p;
  logic [10:0] s;
  logic [10:0] m;
  logic [10:0] sum;

  assign p   = {1'b0, pos};
  assign s   = {7'd0, step};
  assign m   = {1'b0, max};
  assign sum = p + s;

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    if (step != 4'd0) begin
      if (dir == DIR_INC) begin
        if (sum >= m) begin
          next_pos = max;
          next_dir = DIR_DEC;
        end else begin
          next_pos = sum[9:0];
        end
      end else begin
        // pos == step lands exactly on 0, which is also an edge
        if (p <= s) begin
          next_pos = 10'd0;
          next_dir = DIR_INC;
        end else begin
          next_pos = pos - {6'd0, step};
        end
      end
    end
  end

endmodule

// File: rtl/pic_move_ctrl.sv
// Moves the picture window once per frame and sequences
// picture ROM reads for the pixels inside it.
module pic_move_ctrl
  import vga_pkg::*;
#(
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF,
  parameter int WIDTH  = 350,
  parameter int HEIGHT = 350,
  parameter int ADDR_W = 17
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic [9:0]        pixel_xpos,
  input  logic [9:0]        pixel_ypos,
  input  logic              move_en,
  input  logic [3:0]        step,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_valid,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic              frame_tick
);

  localparam logic [9:0] MAX_X = 10'(H_DISP - WIDTH);
  localparam logic [9:0] MAX_Y = 10'(V_DISP - HEIGHT);
  localparam logic [9:0] RST_X = 10'((H_DISP - WIDTH) / 2);
  localparam logic [9:0] RST_Y = 10'((V_DISP - HEIGHT) / 2);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(WIDTH * HEIGHT - 1);

  move_state_t state;
  logic        dir_x;
  logic        dir_y;
  logic [3:0]  step_q;
  logic        en_q;
  logic        fe_raw;
  logic        fe_q;
  logic        fe_d;
  logic        frame_end;
  logic [3:0]  step_eff;
  logic [9:0]  nx;
  logic [9:0]  ny;
  logic        ndx;
  logic        ndy;
  logic [10:0] x_end;
  logic [10:0] y_end;

  assign x_end = {1'b0, pos_x} + 11'(WIDTH);
  assign y_end = {1'b0, pos_y} + 11'(HEIGHT);

  assign rom_rd_en =
    ({1'b0, pixel_xpos} >= {1'b0, pos_x}) &&
    ({1'b0, pixel_xpos} <  x_end) &&
    ({1'b0, pixel_ypos} >= {1'b0, pos_y}) &&
    ({1'b0, pixel_ypos} <  y_end);

  assign fe_raw = (pixel_xpos == 10'(H_DISP - 1)) &&
                  (pixel_ypos == 10'(V_DISP - 1));
  assign frame_end = fe_q & ~fe_d;

  // Zero step also covers the frozen case
  assign step_eff = en_q ? step_q : 4'd0;

  bounce_axis u_axis_x (
    .pos      (pos_x),
    .dir      (dir_x),
    .step     (step_eff),
    .max      (MAX_X),
    .next_pos (nx),
    .next_dir (ndx)
  );

  bounce_axis u_axis_y (
    .pos      (pos_y),
    .dir      (dir_y),
    .step     (step_eff),
    .max      (MAX_Y),
    .next_pos (ny),
    .next_dir (ndy)
  );

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state      <= ST_WAIT;
      fe_q       <= 1'b0;
      fe_d       <= 1'b0;
      pos_x      <= RST_X;
      pos_y      <= RST_Y;
      dir_x      <= DIR_INC;
      dir_y      <= DIR_INC;
      step_q     <= 4'd0;
      en_q       <= 1'b0;
      rom_addr   <= '0;
      rom_valid  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      fe_q       <= fe_raw;
      fe_d       <= fe_q;
      rom_valid  <= rom_rd_en;
      frame_tick <= 1'b0;
      if (rom_rd_en) begin
        if (rom_addr == LAST) rom_addr <= '0;
        else rom_addr <= rom_addr + ADDR_W'(1);
      end
      unique case (state)
        ST_WAIT: begin
          if (frame_end) state <= ST_CALC;
        end
        ST_CALC: begin
          step_q <= step;
          en_q   <= move_en;
          state  <= ST_COMMIT;
        end
        ST_COMMIT: begin
          pos_x      <= nx;
          pos_y      <= ny;
          dir_x      <= ndx;
          dir_y      <= ndy;
          rom_addr   <= '0;
          frame_tick <= 1'b1;
          state      <= ST_WAIT;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_move_ctrl.sv
// Directed bench for pic_move_ctrl: reset, bounce, freeze,
// window compare and ROM address sequencing.
module tb_pic_move_ctrl;

  logic        vga_clk;
  logic        sys_rst;
  logic [9:0]  pixel_xpos;
  logic [9:0]  pixel_ypos;
  logic        move_en;
  logic [3:0]  step;
  logic        rom_rd_en;
  logic [16:0] rom_addr;
  logic        rom_valid;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        frame_tick;

  logic [9:0]  sx;
  logic [9:0]  sy;
  logic        s_rd_en;
  logic [7:0]  s_addr;
  logic        s_valid;
  logic [9:0]  s_pos_x;
  logic [9:0]  s_pos_y;
  logic        s_tick;

  int checks = 0;
  int errors = 0;

  pic_move_ctrl u_dut (
    .vga_clk    (vga_clk),
    .sys_rst    (sys_rst),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .move_en    (move_en),
    .step       (step),
    .rom_rd_en  (rom_rd_en),
    .rom_addr   (rom_addr),
    .rom_valid  (rom_valid),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .frame_tick (frame_tick)
  );

  pic_move_ctrl #(
    .H_DISP (40),
    .V_DISP (20),
    .WIDTH  (20),
    .HEIGHT (10),
    .ADDR_W (8)
  ) u_small (
    .vga_clk    (vga_clk),
    .sys_rst    (sys_rst),
    .pixel_xpos (sx),
    .pixel_ypos (sy),
    .move_en    (1'b0),
    .step       (4'd0),
    .rom_rd_en  (s_rd_en),
    .rom_addr   (s_addr),
    .rom_valid  (s_valid),
    .pos_x      (s_pos_x),
    .pos_y      (s_pos_y),
    .frame_tick (s_tick)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_xy(input int x, input int y);
    pixel_xpos = 10'(x);
    pixel_ypos = 10'(y);
  endtask

  // Last active pixel for one cycle, then idle coordinates
  task automatic run_frame(input bit chk_tick);
    int hits;
    int at;
    hits = 0;
    at = -1;
    set_xy(639, 479);
    next_cyc();
    set_xy(0, 0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge vga_clk);
      if (frame_tick) begin
        hits++;
        at = i;
      end
      next_cyc();
    end
    if (chk_tick) begin
      check("tick_count", hits, 1);
      check("tick_latency", at, 4);
    end
  endtask

  task automatic frame_pos(input int st, input int ex,
                           input int ey);
    move_en = 1'b1;
    step = 4'(st);
    run_frame(1'b0);
    @(negedge vga_clk);
    check("pos_x", pos_x, ex);
    check("pos_y", pos_y, ey);
  endtask

  initial begin
    int ya[9];
    int yb[18];
    int exp_rd;
    int prev_rd;
    int xe;
    ya = '{84, 99, 114, 129, 130, 115, 100, 85, 70};
    yb = '{43, 28, 13, 0, 15, 30, 45, 60, 75, 90, 105,
           120, 130, 115, 100, 85, 70, 55};
    sys_rst = 1'b1;
    move_en = 1'b0;
    step = 4'd0;
    set_xy(0, 0);
    sx = 10'd0;
    sy = 10'd0;
    repeat (3) @(posedge vga_clk);
    #1;
    @(negedge vga_clk);
    check("rst_pos_x", pos_x, 145);
    check("rst_pos_y", pos_y, 65);
    check("rst_addr", rom_addr, 0);
    check("rst_valid", rom_valid, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_small_x", s_pos_x, 10);
    check("rst_small_y", s_pos_y, 5);
    next_cyc();
    sys_rst = 1'b0;

    // Address sequencing over the first two window rows
    prev_rd = 0;
    for (int y = 65; y <= 66; y++) begin
      xe = (y == 65) ? 496 : 150;
      for (int x = 143; x <= xe; x++) begin
        set_xy(x, y);
        @(negedge vga_clk);
        exp_rd = (x >= 145 && x <= 494) ? 1 : 0;
        check("rd_en", rom_rd_en, exp_rd);
        check("valid", rom_valid, prev_rd);
        if (x == 145 && y == 65) check("addr_first", rom_addr, 0);
        if (x == 494 && y == 65) check("addr_row0_end", rom_addr, 349);
        if (x == 145 && y == 66) check("addr_row1", rom_addr, 350);
        prev_rd = exp_rd;
        next_cyc();
      end
    end

    // Window boundary corners
    set_xy(145, 64);
    @(negedge vga_clk);
    check("rd_above", rom_rd_en, 0);
    set_xy(494, 414);
    @(negedge vga_clk);
    check("rd_corner", rom_rd_en, 1);
    set_xy(495, 414);
    @(negedge vga_clk);
    check("rd_right", rom_rd_en, 0);
    set_xy(494, 415);
    @(negedge vga_clk);
    check("rd_below", rom_rd_en, 0);
    next_cyc();

    // Full wrap on the small instance (window 20x10 at 10,5)
    for (int y = 5; y <= 14; y++) begin
      for (int x = 10; x <= 29; x++) begin
        sx = 10'(x);
        sy = 10'(y);
        @(negedge vga_clk);
        if (x == 10 && y == 5) check("s_first", s_addr, 0);
        if (x == 29 && y == 5) check("s_row0_end", s_addr, 19);
        if (x == 10 && y == 6) check("s_row1", s_addr, 20);
        if (x == 29 && y == 14) begin
          check("s_last_rd", s_rd_en, 1);
          check("s_last_addr", s_addr, 199);
        end
        next_cyc();
      end
    end
    sx = 10'd0;
    sy = 10'd0;
    @(negedge vga_clk);
    check("s_wrap_addr", s_addr, 0);
    check("s_wrap_valid", s_valid, 1);
    check("s_idle_rd", s_rd_en, 0);
    next_cyc();

    // Straight move
    move_en = 1'b1;
    step = 4'd4;
    run_frame(1'b1);
    @(negedge vga_clk);
    check("move_x", pos_x, 149);
    check("move_y", pos_y, 69);
    check("commit_addr", rom_addr, 0);

    // Walk toward the right edge, Y bouncing off bottom
    for (int i = 0; i < 9; i++)
      frame_pos(15, 149 + 15 * (i + 1), ya[i]);
    frame_pos(4, 288, 66);
    frame_pos(4, 290, 62);
    frame_pos(4, 286, 58);

    // Walk toward the left edge, Y bouncing both ways
    for (int i = 0; i < 18; i++)
      frame_pos(15, 286 - 15 * (i + 1), yb[i]);
    frame_pos(13, 3, 42);
    frame_pos(4, 0, 38);
    frame_pos(4, 4, 34);

    // Freeze; address still cleared on each commit
    for (int f = 0; f < 2; f++) begin
      set_xy(4, 34);
      repeat (5 - 2 * f) next_cyc();
      @(negedge vga_clk);
      check("frz_addr_pre", rom_addr, 5 - 2 * f);
      move_en = 1'b0;
      step = 4'd9;
      run_frame(1'b0);
      @(negedge vga_clk);
      check("frz_addr", rom_addr, 0);
      check("frz_x", pos_x, 4);
      check("frz_y", pos_y, 34);
    end
    frame_pos(0, 4, 34);
    frame_pos(4, 8, 30);

    // Reset mid-line
    set_xy(300, 200);
    sys_rst = 1'b1;
    next_cyc();
    @(negedge vga_clk);
    check("mrst_x", pos_x, 145);
    check("mrst_y", pos_y, 65);
    check("mrst_addr", rom_addr, 0);
    check("mrst_valid", rom_valid, 0);
    check("mrst_tick", frame_tick, 0);
    next_cyc();
    sys_rst = 1'b0;
    next_cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
